// File: rtl/alu_exec_stage.sv
// alu_exec_stage: round-robin issue from the ALU reservation stations, one-cycle
// execute, and a single-cycle completion broadcast back to the station and ROB.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   flush          tag-window flush (valid, front_tag, flush_tag)
//   data           station entries (tag, opcodes, operands, valid)
//   acu_operation  per entry: 1 = comparator op, 0 = ALU op
//   ready          per entry: valid with both operands resolved
//   broadcast_bus  per-entry completion pulse carrying tag and result
//   busy           issue or result register occupied
package alu_exec_pkg;
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_XOR, ALU_OR, ALU_AND
    } alu_ops;
    typedef enum logic [2:0] {
        CMP_BEQ, CMP_BNE, CMP_BLT, CMP_BGE, CMP_BLTU, CMP_BGEU
    } cmp_ops;
    typedef struct packed {
        logic       valid;
        logic [3:0] front_tag;
        logic [3:0] flush_tag;
    } flush_t;
    typedef struct packed {
        logic        valid;
        logic [3:0]  tag;
        alu_ops      alu_opcode;
        cmp_ops      cmp_opcode;
        logic [31:0] r1;
        logic [31:0] r2;
    } rs_t;
    typedef struct packed {
        logic        rdy;
        logic [3:0]  tag;
        logic [31:0] data;
    } sal_t;
endpackage

module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int size = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  flush_t            flush,
    input  rs_t   [size-1:0]  data,
    input  logic  [size-1:0]  acu_operation,
    input  logic  [size-1:0]  ready,
    output sal_t  [size-1:0]  broadcast_bus,
    output logic              busy
);
    localparam int iw = $clog2(size);

    logic [size-1:0] eligible, in_flight, in_flight_next, valid_mask;
    logic [iw-1:0]   ptr, gnt, idx, oidx;
    logic            found, grant, kill_issue, iv, ov, iacu, cmp_res, unused_valid;
    logic [3:0]      itag, otag;
    alu_ops          ialu;
    cmp_ops          icmp;
    logic [31:0]     ir1, ir2, alu_res, odata;

    // Tag window [front, back) on a 16-entry circular tag space.
    function automatic logic in_window(input logic [3:0] t, input logic [3:0] front,
                                       input logic [3:0] back);
        return front <= back ? (t >= front && t < back) : (t >= front || t < back);
    endfunction

    assign eligible   = ready & ~in_flight;
    assign grant      = found && !flush.valid;
    assign kill_issue = flush.valid && iv && in_window(itag, flush.front_tag, flush.flush_tag);
    assign busy       = iv | ov;
    // The station folds valid into ready, so the entry valid bit is not consulted here.
    assign unused_valid = ^valid_mask;

    always_comb begin
        for (int i = 0; i < size; i++) valid_mask[i] = data[i].valid;
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        gnt   = ptr;
        found = 1'b0;
        for (int k = size - 1; k >= 0; k--) begin
            if (eligible[ptr + iw'(k)]) begin
                gnt   = ptr + iw'(k);
                found = 1'b1;
            end
        end
    end

    // Grant sets last so a freshly granted entry always shows as in flight.
    always_comb begin
        in_flight_next = in_flight;
        if (ov) in_flight_next[oidx] = 1'b0;
        if (kill_issue) in_flight_next[idx] = 1'b0;
        if (grant) in_flight_next[gnt] = 1'b1;
    end

    always_comb begin
        case (ialu)
            ALU_ADD: alu_res = ir1 + ir2;
            ALU_SUB: alu_res = ir1 - ir2;
            ALU_SLL: alu_res = ir1 << ir2[4:0];
            ALU_SRL: alu_res = ir1 >> ir2[4:0];
            ALU_SRA: alu_res = 32'($signed(ir1) >>> ir2[4:0]);
            ALU_XOR: alu_res = ir1 ^ ir2;
            ALU_OR:  alu_res = ir1 | ir2;
            default: alu_res = ir1 & ir2;
        endcase
    end

    always_comb begin
        case (icmp)
            CMP_BEQ:  cmp_res = ir1 == ir2;
            CMP_BNE:  cmp_res = ir1 != ir2;
            CMP_BLT:  cmp_res = $signed(ir1) < $signed(ir2);
            CMP_BGE:  cmp_res = $signed(ir1) >= $signed(ir2);
            CMP_BLTU: cmp_res = ir1 < ir2;
            CMP_BGEU: cmp_res = ir1 >= ir2;
            default:  cmp_res = 1'b0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < size; i++)
            broadcast_bus[i] = (ov && oidx == iw'(i)) ? {1'b1, otag, odata} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iv        <= 1'b0;
            ov        <= 1'b0;
            ptr       <= '0;
            in_flight <= '0;
            idx       <= '0;
            itag      <= '0;
            ialu      <= ALU_ADD;
            icmp      <= CMP_BEQ;
            iacu      <= 1'b0;
            ir1       <= '0;
            ir2       <= '0;
            oidx      <= '0;
            otag      <= '0;
            odata     <= '0;
        end else begin
            iv <= grant;
            if (grant) begin
                idx  <= gnt;
                itag <= data[gnt].tag;
                ialu <= data[gnt].alu_opcode;
                icmp <= data[gnt].cmp_opcode;
                iacu <= acu_operation[gnt];
                ir1  <= data[gnt].r1;
                ir2  <= data[gnt].r2;
                ptr  <= gnt + iw'(1);
            end
            ov        <= iv && !kill_issue;
            oidx      <= idx;
            otag      <= itag;
            odata     <= iacu ? {31'b0, cmp_res} : alu_res;
            in_flight <= in_flight_next;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and randomized checks of alu_exec_stage against a
// cycle-level reference model of the station, arbiter and flush rules.
module tb_alu_exec_stage;
    import alu_exec_pkg::*;

    localparam int SIZE = 8;
    localparam int MAXC = 1200;

    logic              clk = 1'b0;
    logic              rst;
    flush_t            flush;
    rs_t  [SIZE-1:0]   data;
    logic [SIZE-1:0]   acu_operation;
    logic [SIZE-1:0]   ready;
    sal_t [SIZE-1:0]   broadcast_bus;
    logic              busy;

    alu_exec_stage #(.size(SIZE)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .data(data),
        .acu_operation(acu_operation),
        .ready(ready),
        .broadcast_bus(broadcast_bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc;
    int          ptr_m;
    int          busy_until[SIZE];
    int          exp_idx[MAXC];
    logic [3:0]  exp_tag[MAXC];
    logic [31:0] exp_data[MAXC];
    bit          granted[MAXC];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [3:0] t);
        int d, w;
        d = (int'(t) - int'(flush.front_tag) + 16) % 16;
        w = (int'(flush.flush_tag) - int'(flush.front_tag) + 16) % 16;
        return d < w;
    endfunction

    function automatic logic [31:0] ref_result(input rs_t e, input logic acu);
        int     sa = int'(e.r1);
        int     sb = int'(e.r2);
        longint ua = longint'({32'b0, e.r1});
        longint ub = longint'({32'b0, e.r2});
        int     sh = int'(e.r2 % 32);
        if (acu) begin
            case (e.cmp_opcode)
                CMP_BEQ:  return 32'(ua == ub);
                CMP_BNE:  return 32'(ua != ub);
                CMP_BLT:  return 32'(sa < sb);
                CMP_BGE:  return 32'(sa >= sb);
                CMP_BLTU: return 32'(ua < ub);
                default:  return 32'(ua >= ub);
            endcase
        end
        case (e.alu_opcode)
            ALU_ADD: return 32'(ua + ub);
            ALU_SUB: return 32'(ua - ub);
            ALU_SLL: return 32'(ua << sh);
            ALU_SRL: return 32'(ua >> sh);
            ALU_SRA: return 32'(sa >>> sh);
            ALU_XOR: return e.r1 ^ e.r2;
            ALU_OR:  return e.r1 | e.r2;
            default: return e.r1 & e.r2;
        endcase
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < SIZE; i++) begin
            sal_t e;
            e = (exp_idx[cyc] == i) ? {1'b1, exp_tag[cyc], exp_data[cyc]} : '0;
            check($sformatf("bus[%0d]@%0d", i, cyc), 64'(broadcast_bus[i]), 64'(e));
        end
        check($sformatf("busy@%0d", cyc), 64'(busy), 64'(granted[cyc-1] || exp_idx[cyc] >= 0));
    endtask

    // Model one cycle with the inputs now applied, cross the clock edge, then check.
    task automatic step();
        int c = cyc;
        granted[c] = 1'b0;
        if (rst) begin
            for (int k = 0; k < SIZE; k++) busy_until[k] = -1;
            exp_idx[c+1] = -1;
            exp_idx[c+2] = -1;
            ptr_m = 0;
            ready = '0;
        end else if (flush.valid) begin
            if (exp_idx[c+1] >= 0 && in_win(exp_tag[c+1])) begin
                busy_until[exp_idx[c+1]] = -1;
                exp_idx[c+1] = -1;
            end
            for (int k = 0; k < SIZE; k++) if (in_win(data[k].tag)) ready[k] = 1'b0;
        end else begin
            for (int o = 0; o < SIZE; o++) begin
                int k;
                k = (ptr_m + o) % SIZE;
                if (ready[k] && busy_until[k] < c) begin
                    granted[c]    = 1'b1;
                    exp_idx[c+2]  = k;
                    exp_tag[c+2]  = data[k].tag;
                    exp_data[c+2] = ref_result(data[k], acu_operation[k]);
                    busy_until[k] = c + 2;
                    ptr_m = (k + 1) % SIZE;
                    break;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
        if (exp_idx[cyc] >= 0) ready[exp_idx[cyc]] = 1'b0;
    endtask

    task automatic load(input int k, input logic [3:0] t, input alu_ops a, input cmp_ops m,
                        input logic acu, input logic [31:0] x, input logic [31:0] y);
        data[k] = '{valid: 1'b1, tag: t, alu_opcode: a, cmp_opcode: m, r1: x, r2: y};
        acu_operation[k] = acu;
        ready[k] = 1'b1;
    endtask

    task automatic load_random(input int k);
        logic [31:0] x, y;
        x = $urandom;
        y = $urandom;
        case ($urandom_range(0, 3))
            0: y = x;
            1: x = 32'h8000_0000;
            default: ;
        endcase
        load(k, 4'($urandom_range(0, 15)), alu_ops'($urandom_range(0, 7)),
             cmp_ops'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), x, y);
    endtask

    task automatic expect_bus(input string name, input int k, input logic rdy, input logic [31:0] d);
        check({name, "_rdy"}, 64'(broadcast_bus[k].rdy), 64'(rdy));
        check({name, "_data"}, 64'(broadcast_bus[k].data), 64'(d));
    endtask

    initial begin
        rst = 1'b1;
        flush = '0;
        data = '0;
        ready = '0;
        acu_operation = '0;
        ptr_m = 0;
        for (int k = 0; k < SIZE; k++) busy_until[k] = -1;
        for (int c = 0; c < MAXC; c++) begin
            exp_idx[c] = -1;
            granted[c] = 1'b0;
        end
        repeat (2) @(negedge clk);
        cyc = 1;
        check_outputs();
        check("reset_busy", 64'(busy), 64'(0));
        rst = 1'b0;

        // single add
        load(2, 4'd3, ALU_ADD, CMP_BEQ, 1'b0, 32'd5, 32'd7);
        step();
        check("add_busy_c1", 64'(busy), 64'(1));
        step();
        expect_bus("add_c2", 2, 1'b1, 32'd12);
        check("add_tag", 64'(broadcast_bus[2].tag), 64'(3));
        check("add_busy_c2", 64'(busy), 64'(1));
        step();
        expect_bus("add_c3", 2, 1'b0, 32'd0);
        check("add_busy_c3", 64'(busy), 64'(0));

        // round robin from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(0, 4'd1, ALU_ADD, CMP_BEQ, 1'b0, 32'd1, 32'd1);
        load(1, 4'd2, ALU_OR, CMP_BEQ, 1'b0, 32'hF0, 32'h0F);
        load(5, 4'd4, ALU_SLL, CMP_BEQ, 1'b0, 32'd1, 32'd4);
        step();
        step();
        expect_bus("rr_e0", 0, 1'b1, 32'd2);
        step();
        expect_bus("rr_e1", 1, 1'b1, 32'hFF);
        step();
        expect_bus("rr_e5", 5, 1'b1, 32'd16);
        step();

        // compare and shift
        load(0, 4'd5, ALU_ADD, CMP_BLT, 1'b1, 32'hFFFF_FFFF, 32'd1);
        load(1, 4'd6, ALU_ADD, CMP_BLTU, 1'b1, 32'hFFFF_FFFF, 32'd1);
        load(2, 4'd7, ALU_SRA, CMP_BEQ, 1'b0, 32'h8000_0000, 32'h21);
        load(3, 4'd8, ALU_SUB, CMP_BEQ, 1'b0, 32'd0, 32'd1);
        step();
        step();
        expect_bus("blt", 0, 1'b1, 32'd1);
        step();
        expect_bus("bltu", 1, 1'b1, 32'd0);
        step();
        expect_bus("sra", 2, 1'b1, 32'hC000_0000);
        step();
        expect_bus("sub", 3, 1'b1, 32'hFFFF_FFFF);
        step();

        // flush of the issue register, plain window then wrapped window
        for (int s = 0; s < 2; s++) begin
            load(4, s == 0 ? 4'd6 : 4'd0, ALU_ADD, CMP_BEQ, 1'b0, 32'd10, 32'd20);
            step();
            flush = s == 0 ? '{valid: 1'b1, front_tag: 4'd5, flush_tag: 4'd7}
                           : '{valid: 1'b1, front_tag: 4'd12, flush_tag: 4'd2};
            step();
            expect_bus($sformatf("flush_kill%0d", s), 4, 1'b0, 32'd0);
            check($sformatf("flush_busy%0d", s), 64'(busy), 64'(0));
            flush.valid = 1'b0;
            load(4, 4'd9, ALU_ADD, CMP_BEQ, 1'b0, 32'd1, 32'd2);
            step();
            step();
            expect_bus($sformatf("flush_regrant%0d", s), 4, 1'b1, 32'd3);
            step();
        end

        // reset the cycle after a grant
        load(6, 4'd5, ALU_ADD, CMP_BEQ, 1'b0, 32'd100, 32'd200);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_bus("rst_mid", 6, 1'b0, 32'd0);
        check("rst_mid_busy", 64'(busy), 64'(0));
        step();
        expect_bus("rst_mid_after", 6, 1'b0, 32'd0);
        load(3, 4'd1, ALU_XOR, CMP_BEQ, 1'b0, 32'hFF, 32'h0F);
        load(7, 4'd2, ALU_AND, CMP_BEQ, 1'b0, 32'hFF, 32'h0F);
        step();
        step();
        expect_bus("ptr_reset", 3, 1'b1, 32'hF0);
        step();
        expect_bus("ptr_next", 7, 1'b1, 32'h0F);
        step();

        // randomized traffic with flushes and occasional resets
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < SIZE; k++)
                if (!ready[k] && $urandom_range(0, 2) == 0) load_random(k);
            flush.valid = ($urandom_range(0, 9) == 0);
            flush.front_tag = 4'($urandom_range(0, 15));
            flush.flush_tag = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        flush.valid = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
